// File: rtl/modn_down_timer.sv
// Mod-N down-counting timer with IDLE/RUN control, one-shot or free-run mode,
// and a synchronous load that clamps out-of-range values to N-1.
//
// state | meaning
// IDLE  | q holds (except on load), tc stays low
// RUN   | q counts down, wraps 0 -> N-1 with a one-cycle tc pulse
module modn_down_timer #(
  parameter int N     = 12,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             load_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(N - 1);

  state_t state;
  logic   mode_oneshot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mode_oneshot <= 1'b0;
      q            <= QMAX;
      tc           <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state        <= RUN;
            mode_oneshot <= oneshot;
          end
        end
        RUN: begin
          // A load suppresses the wrap, so it also suppresses the one-shot exit.
          if (stop)
            state <= IDLE;
          else if (!load && (q == '0) && mode_oneshot)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        if (load_val > QMAX) begin
          q        <= QMAX;
          load_err <= 1'b1;
        end else begin
          q <= load_val;
        end
      end else if ((state == RUN) && !stop) begin
        if (q == '0) begin
          q  <= QMAX;
          tc <= 1'b1;
        end else begin
          q <= q - WIDTH'(1);
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule
